// File: rtl/diad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : diad_pkg
// Description : Shared widths and fetch-stage state encoding for the diad
//               pipeline front end.
// Revision    : 1.0 - initial release
// ============================================================================
package diad_pkg;

    // Default program-counter and instruction word widths
    localparam int c_PC_W    = 12;
    localparam int c_INSTR_W = 24;

    // Instruction-fetch stage occupancy
    //   ST_EMPTY : nothing in flight
    //   ST_WAIT  : memory read in flight, data on mem_rdata this cycle
    //   ST_HOLD  : instruction captured locally, downstream stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage : diad_pkg
`default_nettype wire

// File: rtl/stage1if_skid.sv
`default_nettype none
// ============================================================================
// Module      : stage1if_skid
// Description : Hold register for the fetch stage. Captures the memory word
//               when the downstream stalls on a live read, and selects the
//               live word, the held word or zero for the stage output.
// Revision    : 1.0 - initial release
// ============================================================================
module stage1if_skid #(
    parameter int INSTR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_sel_live,
    input  logic               i_sel_hold,
    input  logic [INSTR_W-1:0] i_mem_rdata,
    output logic [INSTR_W-1:0] o_instr
);

    logic [INSTR_W-1:0] r_hold_q;

    // Capture the live memory word when it cannot be delivered this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_q <= '0;
        end else if (i_load) begin
            r_hold_q <= i_mem_rdata;
        end
    end

    // Output select: held word wins, then the live word, otherwise zero
    always_comb begin
        o_instr = '0;
        if (i_sel_hold) begin
            o_instr = r_hold_q;
        end else if (i_sel_live) begin
            o_instr = i_mem_rdata;
        end
    end

endmodule : stage1if_skid
`default_nettype wire

// File: rtl/stage1if.sv
`default_nettype none
// ============================================================================
// Module      : stage1if
// Description : Instruction-fetch stage. Tracks one outstanding memory read,
//               presents the returned word with its PC one cycle after the
//               address, holds it across downstream stalls, and discards
//               everything on flush. Counts delivered instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module stage1if
    import diad_pkg::*;
#(
    parameter int PC_W    = c_PC_W,
    parameter int INSTR_W = c_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               stall_in,
    input  logic               flush_in,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               enable_out,
    output logic               stall_out,
    output logic [15:0]        fetch_count
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [PC_W-1:0]   r_pc_q;
    logic [15:0]       r_fetch_count;
    logic              w_accept;
    logic              w_in_wait;
    logic              w_in_hold;
    logic              w_deliver;

    assign w_in_wait  = (r_state == ST_WAIT);
    assign w_in_hold  = (r_state == ST_HOLD);

    // A held instruction blocks upstream even if downstream frees up this cycle
    assign stall_out  = stall_in | w_in_hold;
    assign w_accept   = enable_in & ~stall_out & ~flush_in;
    assign enable_out = (w_in_wait | w_in_hold) & ~flush_in;
    assign w_deliver  = enable_out & ~stall_in;
    assign pc_out     = r_pc_q;
    assign fetch_count = r_fetch_count;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides stall and accept
    always_comb begin
        w_state_next = r_state;
        if (flush_in) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: w_state_next = w_accept ? ST_WAIT : ST_EMPTY;
                ST_WAIT: begin
                    if (stall_in) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_state_next = w_accept ? ST_WAIT : ST_EMPTY;
                    end
                end
                ST_HOLD:  w_state_next = stall_in ? ST_HOLD : ST_EMPTY;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Latch the PC of each accepted address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_q <= '0;
        end else if (w_accept) begin
            r_pc_q <= pc_in;
        end
    end

    // Delivered-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_deliver) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    stage1if_skid #(
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_in_wait & stall_in & ~flush_in),
        .i_sel_live  (w_in_wait & ~flush_in),
        .i_sel_hold  (w_in_hold & ~flush_in),
        .i_mem_rdata (mem_rdata),
        .o_instr     (instr_out)
    );

endmodule : stage1if
`default_nettype wire

// File: tb/tb_stage1if.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage1if
// Description : Self-checking bench for stage1if. The driver keeps a
//               transaction-level model of the stage and pushes every
//               accepted fetch into a scoreboard queue; the monitor compares
//               presented and delivered instructions against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage1if;

    localparam int c_PC_W    = 12;
    localparam int c_INSTR_W = 24;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable_in;
    logic [c_PC_W-1:0]    pc_in;
    logic [c_INSTR_W-1:0] mem_rdata;
    logic                 stall_in;
    logic                 flush_in;
    logic [c_PC_W-1:0]    pc_out;
    logic [c_INSTR_W-1:0] instr_out;
    logic                 enable_out;
    logic                 stall_out;
    logic [15:0]          fetch_count;

    stage1if #(
        .PC_W    (c_PC_W),
        .INSTR_W (c_INSTR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_in   (enable_in),
        .pc_in       (pc_in),
        .mem_rdata   (mem_rdata),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .enable_out  (enable_out),
        .stall_out   (stall_out),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents
    logic [c_INSTR_W-1:0] mem [4096];

    // Scoreboard of accepted fetches {pc, instr}, oldest first
    logic [c_PC_W+c_INSTR_W-1:0] sb_q [$];

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: one fetched item may be on the output; it is
    // "shown" once it has been presented at least once without being taken.
    bit                m_pres;
    bit                m_shown;
    logic [c_PC_W-1:0] m_pc;
    logic [15:0]       m_count;

    // Expected per-cycle outputs, published by the driver for the monitor
    bit                e_enable;
    bit                e_stall_out;
    logic [15:0]       e_count;
    bit                mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pres  = 1'b0;
        m_shown = 1'b0;
        m_pc    = '0;
        m_count = '0;
        sb_q.delete();
    endtask

    // One clock cycle of upstream/downstream stimulus plus model update
    task automatic cycle(input bit en, input logic [c_PC_W-1:0] pc, input bit st, input bit fl);
        bit acc;
        bit consumed;
        @(posedge clk);
        #1;
        enable_in   = en;
        pc_in       = pc;
        stall_in    = st;
        flush_in    = fl;
        e_stall_out = st | (m_pres & m_shown);
        e_enable    = m_pres & ~fl;
        e_count     = m_count;
        // Memory returns data for the address issued last cycle; otherwise junk
        mem_rdata   = (m_pres && !m_shown) ? mem[m_pc] : c_INSTR_W'($urandom);
        acc         = en & ~e_stall_out & ~fl;
        consumed    = e_enable & ~st;
        if (fl) begin
            sb_q.delete();
            m_pres = 1'b0;
        end else if (m_pres && !consumed) begin
            m_shown = 1'b1;
        end else begin
            m_pres = 1'b0;
        end
        if (consumed) m_count = m_count + 16'd1;
        if (acc) begin
            m_pres  = 1'b1;
            m_shown = 1'b0;
            m_pc    = pc;
            sb_q.push_back({pc, mem[pc]});
        end
        mon_en = 1'b1;
    endtask

    // Monitor: compare every cycle's outputs with the model and scoreboard
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("enable_out", {31'd0, enable_out}, {31'd0, e_enable});
            chk("stall_out", {31'd0, stall_out}, {31'd0, e_stall_out});
            chk("fetch_count", {16'd0, fetch_count}, {16'd0, e_count});
            if (!enable_out) begin
                chk("instr_zero", {8'd0, instr_out}, 32'd0);
            end else if (sb_q.size() == 0) begin
                chk("unexpected_output", {20'd0, pc_out}, 32'hFFFF_FFFF);
            end else begin
                chk("pc_out", {20'd0, pc_out}, {20'd0, sb_q[0][c_PC_W+c_INSTR_W-1:c_INSTR_W]});
                chk("instr_out", {8'd0, instr_out}, {8'd0, sb_q[0][c_INSTR_W-1:0]});
                if (!stall_in) void'(sb_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [c_PC_W-1:0] pc;
        for (int i = 0; i < 4096; i++) mem[i] = c_INSTR_W'($urandom);
        mem[12'h020] = 24'hABCDEF;

        // Power-on reset, checked asynchronously before any clock edge
        rst = 1'b1; enable_in = 1'b0; pc_in = '0; mem_rdata = '0;
        stall_in = 1'b1; flush_in = 1'b0;
        model_reset();
        #2;
        chk("rst_enable_out", {31'd0, enable_out}, 32'd0);
        chk("rst_pc_out", {20'd0, pc_out}, 32'd0);
        chk("rst_instr_out", {8'd0, instr_out}, 32'd0);
        chk("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
        chk("rst_stall_out_hi", {31'd0, stall_out}, 32'd1);
        stall_in = 1'b0;
        #1;
        chk("rst_stall_out_lo", {31'd0, stall_out}, 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;

        // Streaming three back-to-back fetches
        cycle(1, 12'h010, 0, 0);
        cycle(1, 12'h011, 0, 0);
        cycle(1, 12'h012, 0, 0);
        cycle(0, 12'h000, 0, 0);
        cycle(0, 12'h000, 0, 0);
        @(negedge clk);
        chk("stream_count", {16'd0, fetch_count}, 32'd3);

        // Stall capture: held word survives changing mem_rdata
        cycle(1, 12'h020, 0, 0);
        cycle(0, 12'h000, 1, 0);
        cycle(0, 12'h000, 1, 0);
        cycle(0, 12'h000, 1, 0);
        @(negedge clk);
        chk("hold_instr", {8'd0, instr_out}, 32'h00ABCDEF);
        chk("hold_stall_out", {31'd0, stall_out}, 32'd1);
        cycle(0, 12'h000, 0, 0);
        cycle(0, 12'h000, 0, 0);
        @(negedge clk);
        chk("hold_count", {16'd0, fetch_count}, 32'd4);

        // Flush while holding, with a competing address
        cycle(1, 12'h030, 0, 0);
        cycle(0, 12'h000, 1, 0);
        cycle(0, 12'h000, 1, 0);
        cycle(1, 12'h031, 1, 1);
        cycle(0, 12'h000, 0, 0);
        cycle(0, 12'h000, 0, 0);
        @(negedge clk);
        chk("flush_hold_count", {16'd0, fetch_count}, 32'd4);

        // Flush beats a simultaneous accept
        cycle(1, 12'h040, 0, 1);
        cycle(0, 12'h000, 0, 0);
        cycle(0, 12'h000, 0, 0);
        @(negedge clk);
        chk("flush_acc_count", {16'd0, fetch_count}, 32'd4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 7), c_PC_W'($urandom),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
        end
        cycle(0, 12'h000, 0, 0);
        cycle(0, 12'h000, 0, 0);

        // Asynchronous reset in the middle of an outstanding read
        cycle(1, 12'h055, 0, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        enable_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        mem_rdata = mem[12'h055];
        #1;
        chk("mid_wait_enable", {31'd0, enable_out}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_enable_out", {31'd0, enable_out}, 32'd0);
        chk("async_pc_out", {20'd0, pc_out}, 32'd0);
        chk("async_instr_out", {8'd0, instr_out}, 32'd0);
        chk("async_fetch_count", {16'd0, fetch_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;

        // Counter wrap via continuous streaming after reset
        pc = 12'h100;
        while (m_count != 16'hFFFE) begin
            cycle(1, pc, 0, 0);
            pc = pc + 12'd1;
        end
        cycle(0, 12'h000, 0, 0);
        cycle(0, 12'h000, 0, 0);
        @(negedge clk);
        chk("count_ffff", {16'd0, fetch_count}, 32'h0000FFFF);
        cycle(1, 12'h200, 0, 0);
        cycle(0, 12'h000, 0, 0);
        cycle(0, 12'h000, 0, 0);
        @(negedge clk);
        chk("count_wrap", {16'd0, fetch_count}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stage1if
`default_nettype wire
